// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl
// Purpose  : Sequences the program counter through one program run: entry
//            point selection, conditional branch resolution, halt and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module run_ctrl #(
    parameter int PC_W    = 10,
    parameter int LUT_AW  = 4,
    parameter int MAX_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        prog_sel,
    input  logic              cfg_we,
    input  logic [LUT_AW-1:0] cfg_addr,
    input  logic [PC_W-1:0]   cfg_data,
    input  logic              br_req,
    input  logic              br_cond,
    input  logic [LUT_AW-1:0] br_idx,
    input  logic              halt,
    output logic              pc_reset,
    output logic              pc_start,
    output logic              branch_en,
    output logic [PC_W-1:0]   target,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       cycle_cnt
);

    localparam int          c_DEPTH   = 2 ** LUT_AW;
    localparam logic [15:0] c_LAST_CYC = 16'(MAX_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    logic [1:0]        r_prog_sel_q;
    logic [15:0]       r_cycle_cnt;
    logic              r_timeout;
    logic [PC_W-1:0]   r_lut [c_DEPTH];

    logic [LUT_AW-1:0] w_entry_idx;
    logic              w_cfg_ok;

    assign w_entry_idx = LUT_AW'(r_prog_sel_q);
    assign w_cfg_ok    = (r_state == S_IDLE) || (r_state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_prog_sel_q <= 2'd0;
            r_cycle_cnt  <= 16'd0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Clear status on the way into ARM so a new run never shows stale results
                    if (start) begin
                        r_state     <= S_ARM;
                        r_cycle_cnt <= 16'd0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_ARM: begin
                    r_prog_sel_q <= prog_sel;
                    r_cycle_cnt  <= 16'd0;
                    r_timeout    <= 1'b0;
                    if (!start) begin
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + 16'd1;
                    if (halt) begin
                        r_state <= S_DONE;
                    end else if (r_cycle_cnt == c_LAST_CYC) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else if (cfg_we && w_cfg_ok) begin
            r_lut[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        pc_reset  = 1'b0;
        pc_start  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        branch_en = 1'b0;
        target    = '0;
        case (r_state)
            S_IDLE: begin
                pc_reset = 1'b1;
            end
            S_ARM: begin
                pc_start = 1'b1;
                busy     = 1'b1;
            end
            S_LAUNCH: begin
                busy      = 1'b1;
                branch_en = 1'b1;
                target    = r_lut[w_entry_idx];
            end
            S_RUN: begin
                busy      = 1'b1;
                branch_en = br_req & br_cond & ~halt;
                target    = r_lut[br_idx];
            end
            S_DONE: begin
                pc_reset = 1'b1;
                done     = 1'b1;
            end
            default: begin
                pc_reset = 1'b1;
            end
        endcase
    end

    assign timeout   = r_timeout;
    assign cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sequences the program counter for one program execution. It drives the counter's reset, start, branch_en and target inputs, and holds a small configurable branch-target lookup table. It selects the program entry point on launch and resolves conditional branches during execution. It ends the run on halt or on a cycle-budget timeout. It sits between the top-level start/done handshake, the instruction decoder, and the program counter.

## Interface
- PC_W, 10, program counter and target width
- LUT_AW, 4, LUT address width; depth is 2**LUT_AW; entries 0..3 are program entry points
- MAX_CYC, 4096, RUN-cycle budget before timeout; range 1..65535

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- start  in  1  run request level from top level
- prog_sel  in  2  program select; sampled every cycle in ARM
- cfg_we  in  1  LUT write enable
- cfg_addr  in  LUT_AW  LUT write address
- cfg_data  in  PC_W  LUT write data
- br_req  in  1  decoder: current instruction is a conditional branch
- br_cond  in  1  ALU condition flag for current branch
- br_idx  in  LUT_AW  LUT index of branch target
- halt  in  1  decoder: current instruction is halt
- pc_reset  out  1  to counter reset
- pc_start  out  1  to counter start
- branch_en  out  1  to counter branch_en
- target  out  PC_W  to counter target
- busy  out  1  run in progress
- done  out  1  run finished, level
- timeout  out  1  last run ended on budget, level
- cycle_cnt  out  16  RUN cycles in last or current run

## Operation
- States: IDLE, ARM, LAUNCH, RUN, DONE.
- IDLE → ARM on start=1.
- ARM → LAUNCH on start=0; stays in ARM while start=1.
- LAUNCH → RUN unconditionally.
- RUN → DONE on halt=1, or on budget expiry.
- DONE → ARM on start=1.
- start is ignored in LAUNCH and RUN; there is no abort except reset.
- Outputs are decoded from state (combinational):
  - pc_reset=1 in IDLE and DONE
  - pc_start=1 in ARM
  - busy=1 in ARM, LAUNCH and RUN
  - done=1 in DONE
- branch_en/target:
  - LAUNCH: branch_en=1, target=lut[{0,prog_sel_q}].
  - RUN: branch_en = br_req & br_cond & ~halt, target=lut[br_idx]. Both are combinational in the same cycle; the counter latches them on the next edge.
  - All other states: branch_en=0, target=0.
- Simultaneous halt and br_req: halt wins, branch_en=0.
- prog_sel_q is loaded from prog_sel every ARM cycle, so the last ARM value is used.
- LUT:
  - Written on the clock edge when cfg_we=1 and state is IDLE or DONE.
  - Writes are ignored in ARM, LAUNCH and RUN.
  - Reads are asynchronous.
- cycle_cnt:
  - Cleared to 0 in ARM.
  - Increments by 1 on every RUN cycle, including the halt cycle.
  - Held in IDLE, LAUNCH and DONE.
- Budget expiry: in RUN with halt=0 and cycle_cnt==MAX_CYC-1, the counter becomes MAX_CYC, the FSM goes to DONE and timeout is set. cycle_cnt never exceeds MAX_CYC.
- timeout is cleared on entry to ARM. If halt occurs in the expiry cycle, halt wins and timeout=0.

## Timing
- Reset values:
  - state=IDLE, prog_sel_q=0, cycle_cnt=0, timeout=0
  - all LUT entries 0
  - pc_reset=1, pc_start=0, branch_en=0, target=0, busy=0, done=0
- Reset mid-run returns the FSM to IDLE asynchronously and clears the LUT.
- start rises before edge k: ARM from edge k.
- start falls before edge m: LAUNCH for cycle m..m+1, then RUN from edge m+1. The counter therefore lands on the entry address at edge m+1.
- Branch decision to counter update latency: 1 edge.
- halt sampled at edge h: DONE from edge h; pc_reset=1 in the following cycle.
- Minimum run length: 1 RUN cycle.

## Test plan
- Reset: assert reset mid-cycle, check asynchronously: pc_reset=1, busy=0, done=0, cycle_cnt=0, branch_en=0, target=0.
- Launch: in IDLE, write lut[1]=0x040. Set prog_sel=1, start=1 for 2 cycles, then 0. Required: pc_start=1 for 2 cycles, then exactly one cycle with branch_en=1, target=0x040, then busy=1 in RUN.
- Branch: lut[5]=0x123; in RUN apply br_req=1, br_idx=5.
  - br_cond=1 → same-cycle branch_en=1, target=0x123.
  - br_cond=0 → branch_en=0.
  - halt=1 together with a taken branch → branch_en=0.
- Halt: halt on the 7th RUN cycle → done=1, busy=0, cycle_cnt=7, timeout=0, pc_reset=1. Then start pulse → ARM with cycle_cnt=0 and done=0.
- Timeout (MAX_CYC=8): no halt → DONE after the 8th RUN cycle with timeout=1, cycle_cnt=8. With halt on the 8th cycle: timeout=0.
- Guards:
  - cfg_we to lut[1] during RUN → lut[1] unchanged on the next launch.
  - start toggling in RUN → no state change.
  - reset asserted in RUN → IDLE immediately, LUT reads 0.
